alu_arbiter: RTL and testbench



---
 rtl/riscv_pkg.sv | 27 ++
 rtl/alu.sv | 28 ++
 rtl/rr_arb2.sv | 34 +++
 rtl/alu_arbiter.sv | 83 ++++++++
 tb/tb_alu_arbiter.sv | 234 +++++++++++++++++++++++
 5 files changed

// File: rtl/riscv_pkg.sv
// Shared RISC-V core types: ALU op encoding, the arbitrated ALU request bundle
// and the last_grant encoding used by the ALU arbiter.
package riscv_pkg;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_SLL  = 4'd2,
    ALU_SRL  = 4'd3,
    ALU_SRA  = 4'd4,
    ALU_OR   = 4'd5,
    ALU_AND  = 4'd6,
    ALU_XOR  = 4'd7,
    ALU_SLTU = 4'd8,
    ALU_SLT  = 4'd9
  } alu_op_e;

  typedef struct packed {
    logic [31:0] opr_a;
    logic [31:0] opr_b;
    logic [3:0]  op_sel;
  } alu_req_t;

  localparam logic ARB_REQ0 = 1'b0;
  localparam logic ARB_REQ1 = 1'b1;

endpackage

// File: rtl/alu.sv
// Single-cycle combinational integer ALU; unknown op_sel codes yield zero.
module alu
  import riscv_pkg::*;
(
  input  logic [31:0] opr_a,
  input  logic [31:0] opr_b,
  input  logic [3:0]  op_sel,
  output logic [31:0] res
);

  always_comb begin
    res = '0;
    case (op_sel)
      ALU_ADD:  res = opr_a + opr_b;
      ALU_SUB:  res = opr_a - opr_b;
      ALU_SLL:  res = opr_a << opr_b[4:0];
      ALU_SRL:  res = opr_a >> opr_b[4:0];
      ALU_SRA:  res = $unsigned($signed(opr_a) >>> opr_b[4:0]);
      ALU_OR:   res = opr_a | opr_b;
      ALU_AND:  res = opr_a & opr_b;
      ALU_XOR:  res = opr_a ^ opr_b;
      ALU_SLTU: res = {31'b0, (opr_a < opr_b)};
      ALU_SLT:  res = {31'b0, ($signed(opr_a) < $signed(opr_b))};
      default:  res = '0;
    endcase
  end

endmodule

// File: rtl/rr_arb2.sv
// Two-way arbiter: round-robin on conflicts, or req0-wins when FIXED_PRIO is set.
module rr_arb2
  import riscv_pkg::*;
#(
  parameter int unsigned FIXED_PRIO = 0
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [1:0] eligible,
  output logic [1:0] grant
);

  logic last_grant;

  always_comb begin
    grant = '0;
    if (&eligible) begin
      if (FIXED_PRIO != 0)
        grant = 2'b01;
      else
        grant = (last_grant == ARB_REQ1) ? 2'b01 : 2'b10;
    end else begin
      grant = eligible;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      last_grant <= ARB_REQ1;
    else if (|grant)
      last_grant <= grant[1] ? ARB_REQ1 : ARB_REQ0;
  end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one ALU between two valid/ready requesters, returning each result
// through a per-requester registered response slot one cycle after acceptance.
module alu_arbiter
  import riscv_pkg::*;
#(
  parameter int unsigned FIXED_PRIO = 0
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        req0_valid_i,
  output logic        req0_ready_o,
  input  logic [31:0] req0_opr_a_i,
  input  logic [31:0] req0_opr_b_i,
  input  logic [3:0]  req0_op_sel_i,
  output logic        rsp0_valid_o,
  input  logic        rsp0_ready_i,
  output logic [31:0] rsp0_res_o,
  input  logic        req1_valid_i,
  output logic        req1_ready_o,
  input  logic [31:0] req1_opr_a_i,
  input  logic [31:0] req1_opr_b_i,
  input  logic [3:0]  req1_op_sel_i,
  output logic        rsp1_valid_o,
  input  logic        rsp1_ready_i,
  output logic [31:0] rsp1_res_o
);

  alu_req_t    req0, req1, alu_in;
  logic [1:0]  eligible, grant;
  logic [31:0] alu_res;

  // A slot being drained this cycle counts as free, so a slot can refill back-to-back.
  always_comb begin
    req0     = '{opr_a: req0_opr_a_i, opr_b: req0_opr_b_i, op_sel: req0_op_sel_i};
    req1     = '{opr_a: req1_opr_a_i, opr_b: req1_opr_b_i, op_sel: req1_op_sel_i};
    eligible = '0;
    eligible[0] = reset_n & req0_valid_i & (~rsp0_valid_o | rsp0_ready_i);
    eligible[1] = reset_n & req1_valid_i & (~rsp1_valid_o | rsp1_ready_i);
    alu_in   = grant[1] ? req1 : req0;
  end

  assign req0_ready_o = grant[0];
  assign req1_ready_o = grant[1];

  rr_arb2 #(.FIXED_PRIO(FIXED_PRIO)) u_arb (
    .clk      (clk),
    .reset_n  (reset_n),
    .eligible (eligible),
    .grant    (grant)
  );

  alu u_alu (
    .opr_a  (alu_in.opr_a),
    .opr_b  (alu_in.opr_b),
    .op_sel (alu_in.op_sel),
    .res    (alu_res)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rsp0_valid_o <= 1'b0;
      rsp0_res_o   <= '0;
    end else if (grant[0]) begin
      rsp0_valid_o <= 1'b1;
      rsp0_res_o   <= alu_res;
    end else if (rsp0_ready_i) begin
      rsp0_valid_o <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rsp1_valid_o <= 1'b0;
      rsp1_res_o   <= '0;
    end else if (grant[1]) begin
      rsp1_valid_o <= 1'b1;
      rsp1_res_o   <= alu_res;
    end else if (rsp1_ready_i) begin
      rsp1_valid_o <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: round-robin (dut index 0) and fixed-priority
// (dut index 1) instances, with a scoreboard queue per response channel.
module tb_alu_arbiter;
  import riscv_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        req_valid [2][2];
  logic        req_ready [2][2];
  logic [31:0] opa       [2][2];
  logic [31:0] opb       [2][2];
  logic [3:0]  ops       [2][2];
  logic        rsp_valid [2][2];
  logic        rsp_ready [2][2];
  logic [31:0] rsp_res   [2][2];
  logic [31:0] exp_res   [2][2];
  logic [31:0] sbq [4][$];
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  alu_arbiter #(.FIXED_PRIO(0)) dut_rr (
    .clk(clk), .reset_n(reset_n),
    .req0_valid_i(req_valid[0][0]), .req0_ready_o(req_ready[0][0]),
    .req0_opr_a_i(opa[0][0]), .req0_opr_b_i(opb[0][0]), .req0_op_sel_i(ops[0][0]),
    .rsp0_valid_o(rsp_valid[0][0]), .rsp0_ready_i(rsp_ready[0][0]), .rsp0_res_o(rsp_res[0][0]),
    .req1_valid_i(req_valid[0][1]), .req1_ready_o(req_ready[0][1]),
    .req1_opr_a_i(opa[0][1]), .req1_opr_b_i(opb[0][1]), .req1_op_sel_i(ops[0][1]),
    .rsp1_valid_o(rsp_valid[0][1]), .rsp1_ready_i(rsp_ready[0][1]), .rsp1_res_o(rsp_res[0][1])
  );

  alu_arbiter #(.FIXED_PRIO(1)) dut_fp (
    .clk(clk), .reset_n(reset_n),
    .req0_valid_i(req_valid[1][0]), .req0_ready_o(req_ready[1][0]),
    .req0_opr_a_i(opa[1][0]), .req0_opr_b_i(opb[1][0]), .req0_op_sel_i(ops[1][0]),
    .rsp0_valid_o(rsp_valid[1][0]), .rsp0_ready_i(rsp_ready[1][0]), .rsp0_res_o(rsp_res[1][0]),
    .req1_valid_i(req_valid[1][1]), .req1_ready_o(req_ready[1][1]),
    .req1_opr_a_i(opa[1][1]), .req1_opr_b_i(opb[1][1]), .req1_op_sel_i(ops[1][1]),
    .rsp1_valid_o(rsp_valid[1][1]), .rsp1_ready_i(rsp_ready[1][1]), .rsp1_res_o(rsp_res[1][1])
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive(input int d, input int r, input logic v, input logic [31:0] a,
                       input logic [31:0] b, input logic [3:0] op, input logic [31:0] e);
    req_valid[d][r] = v;
    opa[d][r]       = a;
    opb[d][r]       = b;
    ops[d][r]       = op;
    exp_res[d][r]   = e;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int d = 0; d < 2; d++)
      for (int r = 0; r < 2; r++) req_valid[d][r] = 1'b0;
    repeat (n) step();
  endtask

  // Scoreboard monitor: pop before push so a same-cycle drain+refill stays ordered.
  always @(negedge clk) begin
    if (!reset_n) begin
      for (int k = 0; k < 4; k++) sbq[k].delete();
    end else begin
      for (int d = 0; d < 2; d++) begin
        for (int r = 0; r < 2; r++) begin
          if (rsp_valid[d][r] && rsp_ready[d][r]) begin
            if (sbq[d*2+r].size() == 0) begin
              checks++;
              errors++;
              $display("FAIL sb_extra dut%0d rsp%0d: got res %h, expected no response", d, r, rsp_res[d][r]);
            end else begin
              chk($sformatf("sb_res dut%0d rsp%0d", d, r), rsp_res[d][r], sbq[d*2+r].pop_front());
            end
          end
          if (req_valid[d][r] && req_ready[d][r])
            sbq[d*2+r].push_back(exp_res[d][r]);
        end
      end
    end
  end

  initial begin
    for (int d = 0; d < 2; d++)
      for (int r = 0; r < 2; r++) begin
        drive(d, r, 1'b0, '0, '0, '0, '0);
        rsp_ready[d][r] = 1'b1;
      end

    // Reset state, with a pending request that must not see ready
    drive(0, 0, 1'b1, 32'd5, 32'd7, ALU_ADD, 32'd12);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_req0_ready", 32'(req_ready[0][0]), 32'd0);
    chk("rst_rsp0_valid", 32'(rsp_valid[0][0]), 32'd0);
    chk("rst_rsp0_res", rsp_res[0][0], 32'd0);
    chk("rst_rsp1_valid", 32'(rsp_valid[0][1]), 32'd0);
    req_valid[0][0] = 1'b0;
    reset_n = 1'b1;
    step();

    // Single request, ADD 5+7
    drive(0, 0, 1'b1, 32'd5, 32'd7, ALU_ADD, 32'd12);
    @(negedge clk);
    chk("single_ready", 32'(req_ready[0][0]), 32'd1);
    step();
    req_valid[0][0] = 1'b0;
    @(negedge clk);
    chk("single_valid_c1", 32'(rsp_valid[0][0]), 32'd1);
    chk("single_res_c1", rsp_res[0][0], 32'd12);
    step();
    @(negedge clk);
    chk("single_valid_c2", 32'(rsp_valid[0][0]), 32'd0);
    step();

    // Round-robin conflict; req0 was granted last, so req1 leads
    drive(0, 0, 1'b1, 32'd10, 32'd3, ALU_SUB, 32'd7);
    drive(0, 1, 1'b1, 32'h8000_0000, 32'd4, ALU_SRA, 32'hF800_0000);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk($sformatf("rr_ready0 c%0d", i), 32'(req_ready[0][0]), 32'(i % 2));
      chk($sformatf("rr_ready1 c%0d", i), 32'(req_ready[0][1]), 32'((i + 1) % 2));
      step();
    end
    idle(2);

    // Backpressure on slot 0 while req1 proceeds
    rsp_ready[0][0] = 1'b0;
    drive(0, 0, 1'b1, 32'd0, 32'd1, ALU_ADD, 32'd1);
    @(negedge clk);
    chk("bp_fill_ready0", 32'(req_ready[0][0]), 32'd1);
    step();
    drive(0, 0, 1'b1, 32'd2, 32'd3, ALU_ADD, 32'd5);
    drive(0, 1, 1'b1, 32'hFF, 32'h0F, ALU_XOR, 32'hF0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk($sformatf("bp_ready0 c%0d", i), 32'(req_ready[0][0]), 32'd0);
      chk($sformatf("bp_valid0 c%0d", i), 32'(rsp_valid[0][0]), 32'd1);
      chk($sformatf("bp_res0 c%0d", i), rsp_res[0][0], 32'd1);
      chk($sformatf("bp_ready1 c%0d", i), 32'(req_ready[0][1]), 32'd1);
      step();
    end
    rsp_ready[0][0] = 1'b1;
    @(negedge clk);
    chk("bp_refill_ready0", 32'(req_ready[0][0]), 32'd1);
    chk("bp_refill_ready1", 32'(req_ready[0][1]), 32'd0);
    step();
    req_valid[0][0] = 1'b0;
    req_valid[0][1] = 1'b0;
    @(negedge clk);
    chk("bp_refill_res0", rsp_res[0][0], 32'd5);
    idle(2);

    // Signed / unsigned compare and unknown op via req1, back-to-back
    drive(0, 1, 1'b1, 32'hFFFF_FFFF, 32'd1, ALU_SLT, 32'd1);
    @(negedge clk);
    chk("slt_ready", 32'(req_ready[0][1]), 32'd1);
    step();
    drive(0, 1, 1'b1, 32'hFFFF_FFFF, 32'd1, ALU_SLTU, 32'd0);
    @(negedge clk);
    chk("sltu_ready", 32'(req_ready[0][1]), 32'd1);
    step();
    drive(0, 1, 1'b1, 32'hFFFF_FFFF, 32'd1, 4'hF, 32'd0);
    @(negedge clk);
    chk("badop_ready", 32'(req_ready[0][1]), 32'd1);
    step();
    idle(2);

    // Fixed priority instance
    drive(1, 0, 1'b1, 32'd1, 32'd1, ALU_ADD, 32'd2);
    drive(1, 1, 1'b1, 32'd9, 32'd4, ALU_SUB, 32'd5);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk($sformatf("fp_ready0 c%0d", i), 32'(req_ready[1][0]), 32'd1);
      chk($sformatf("fp_ready1 c%0d", i), 32'(req_ready[1][1]), 32'd0);
      step();
    end
    req_valid[1][0] = 1'b0;
    @(negedge clk);
    chk("fp_req1_after_drop", 32'(req_ready[1][1]), 32'd1);
    step();
    idle(2);

    // Reset between grant and consumption
    rsp_ready[0][0] = 1'b0;
    drive(0, 0, 1'b1, 32'd3, 32'd4, ALU_ADD, 32'd7);
    @(negedge clk);
    chk("mid_rst_grant", 32'(req_ready[0][0]), 32'd1);
    step();
    chk("mid_rst_pre_valid", 32'(rsp_valid[0][0]), 32'd1);
    reset_n = 1'b0;
    req_valid[0][0] = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(rsp_valid[0][0]), 32'd0);
    chk("mid_rst_res", rsp_res[0][0], 32'd0);
    step();
    reset_n = 1'b1;
    rsp_ready[0][0] = 1'b1;
    drive(0, 0, 1'b1, 32'hF0F0, 32'hFF00, ALU_AND, 32'hF000);
    drive(0, 1, 1'b1, 32'hF0, 32'h0F, ALU_OR, 32'hFF);
    @(negedge clk);
    chk("post_rst_ready0", 32'(req_ready[0][0]), 32'd1);
    chk("post_rst_ready1", 32'(req_ready[0][1]), 32'd0);
    step();
    @(negedge clk);
    chk("post_rst_ready1_c1", 32'(req_ready[0][1]), 32'd1);
    step();
    idle(3);

    for (int k = 0; k < 4; k++)
      chk($sformatf("sb_drained q%0d", k), 32'(sbq[k].size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
